// File: rtl/stream_interleaver.sv
// Round-robin interleaver: one 2-entry FIFO per input stream, drained in fixed slot order.
// Optional build macro STREAM_INTERLEAVER_ZERO_FILL_EN emits zero samples for empty slots.
module stream_interleaver #(
  parameter int unsigned DWIDTH         = 16,
  parameter int unsigned NR_STREAMS     = 13,
  parameter int unsigned NR_STREAMS_LOG = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NR_STREAMS-1:0]          in_req,
  output logic [NR_STREAMS-1:0]          in_ack,
  input  logic [NR_STREAMS*DWIDTH-1:0]   in_data,
  output logic                           out_req,
  input  logic                           out_ack,
  output logic [DWIDTH-1:0]              out_data,
  output logic [NR_STREAMS_LOG-1:0]      out_stream
);

  localparam int unsigned CNT_W = 2;
  localparam logic [NR_STREAMS_LOG-1:0] LAST_SLOT = NR_STREAMS_LOG'(NR_STREAMS - 1);

  logic [DWIDTH-1:0]         mem [NR_STREAMS][2];
  logic [CNT_W-1:0]          cnt [NR_STREAMS];
  logic [NR_STREAMS-1:0]     wr_ptr;
  logic [NR_STREAMS-1:0]     rd_ptr;
  logic                      out_real;

  logic [NR_STREAMS-1:0]     full;
  logic [NR_STREAMS-1:0]     wr;
  logic [NR_STREAMS-1:0]     pop;
  logic [NR_STREAMS-1:0]     rd_nxt;
  logic [NR_STREAMS-1:0]     nonempty_nxt;
  logic [CNT_W-1:0]          cnt_nxt [NR_STREAMS];
  logic                      xfer;
  logic [NR_STREAMS_LOG-1:0] slot_nxt;
  logic [DWIDTH-1:0]         head_nxt;
  logic                      sel_nonempty;
  logic                      out_req_nxt;
  logic                      out_real_nxt;
  logic [DWIDTH-1:0]         out_data_nxt;

  // Acceptance is gated by reset so nothing is taken while the block is held in reset.
  always_comb begin
    for (int i = 0; i < NR_STREAMS; i++) begin
      full[i] = cnt[i][1];
    end
  end

  assign in_ack = ~full & {NR_STREAMS{~rst}};
  assign wr     = in_req & in_ack;
  assign xfer   = out_req & out_ack;

  // Next FIFO state and the head entry the slot will present after this edge.
  always_comb begin
    pop          = '0;
    rd_nxt       = rd_ptr;
    nonempty_nxt = '0;
    head_nxt     = '0;
    sel_nonempty = 1'b0;
    slot_nxt     = out_stream;
    if (xfer) begin
      slot_nxt = (out_stream == LAST_SLOT) ? '0 : out_stream + NR_STREAMS_LOG'(1);
    end
    for (int i = 0; i < NR_STREAMS; i++) begin
      cnt_nxt[i]      = cnt[i];
      pop[i]          = xfer & out_real & (out_stream == NR_STREAMS_LOG'(i));
      cnt_nxt[i]      = cnt[i] + CNT_W'(wr[i]) - CNT_W'(pop[i]);
      rd_nxt[i]       = rd_ptr[i] ^ pop[i];
      nonempty_nxt[i] = (cnt_nxt[i] != '0);
      if (slot_nxt == NR_STREAMS_LOG'(i)) begin
        sel_nonempty = nonempty_nxt[i];
        // A write landing on the read position becomes the new head.
        if (wr[i] && (wr_ptr[i] == rd_nxt[i])) begin
          head_nxt = in_data[i*DWIDTH +: DWIDTH];
        end else begin
          head_nxt = mem[i][rd_nxt[i]];
        end
      end
    end
  end

  // Presented sample is frozen while the consumer stalls.
  always_comb begin
    out_req_nxt  = out_req;
    out_real_nxt = out_real;
    out_data_nxt = out_data;
    if (!(out_req && !out_ack)) begin
`ifdef STREAM_INTERLEAVER_ZERO_FILL_EN
      out_req_nxt  = |nonempty_nxt;
`else
      out_req_nxt  = sel_nonempty;
`endif
      out_real_nxt = sel_nonempty;
      out_data_nxt = sel_nonempty ? head_nxt : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_STREAMS; i++) begin
        cnt[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_stream <= '0;
      out_req    <= 1'b0;
      out_real   <= 1'b0;
      out_data   <= '0;
    end else begin
      for (int i = 0; i < NR_STREAMS; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      wr_ptr     <= wr_ptr ^ wr;
      rd_ptr     <= rd_nxt;
      out_stream <= slot_nxt;
      out_req    <= out_req_nxt;
      out_real   <= out_real_nxt;
      out_data   <= out_data_nxt;
    end
  end

  // Sample storage needs no reset; validity is tracked by the counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NR_STREAMS; i++) begin
      if (wr[i]) begin
        mem[i][wr_ptr[i]] <= in_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

endmodule

// File: tb/tb_stream_interleaver.sv
// Directed bench for stream_interleaver: reset, latency, stall, backpressure, ordering, async reset.
module tb_stream_interleaver;

  localparam int unsigned DW  = 16;
  localparam int unsigned NS  = 13;
  localparam int unsigned NSL = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     in_req;
  logic [NS-1:0]     in_ack;
  logic [NS*DW-1:0]  in_data;
  logic              out_req;
  logic              out_ack;
  logic [DW-1:0]     out_data;
  logic [NSL-1:0]    out_stream;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  int unsigned wr_seq [NS];
  int unsigned rd_seq [NS];
  logic [NS-1:0] acc;
  int unsigned exp_slot;
  int unsigned wraps;
  int unsigned n_out;

  stream_interleaver #(
    .DWIDTH(DW), .NR_STREAMS(NS), .NR_STREAMS_LOG(NSL)
  ) dut (
    .clk(clk), .rst(rst),
    .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data), .out_stream(out_stream)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input int s, input logic [DW-1:0] v);
    in_data[s*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    in_req  = '0;
    in_data = '0;
    out_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    in_req  = '0;
    in_data = '0;
    out_ack = 1'b0;
    step();
    check("rst_out_req", out_req, 0);
    check("rst_in_ack", in_ack, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_stream", out_stream, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ack", in_ack, 32'h1fff);

    // Single sample on stream 0, one-cycle latency, then idle
    do_reset();
    out_ack = 1'b1;
    set_sample(0, 16'h1234);
    in_req = 13'h0001;
    step();
    in_req = '0;
    check("single_req", out_req, 1);
    check("single_data", out_data, 16'h1234);
    check("single_stream", out_stream, 0);
    step();
    check("single_after_req", out_req, 0);
    check("single_after_stream", out_stream, 1);
    repeat (3) step();
    check("single_idle_req", out_req, 0);

    // Backpressure on stream 0: two accepts, then third after a pop
    do_reset();
    out_ack = 1'b0;
    in_req  = 13'h0001;
    set_sample(0, 16'hA001);
    step();
    check("bp_ack_1", in_ack[0], 1);
    set_sample(0, 16'hA002);
    step();
    check("bp_ack_full", in_ack[0], 0);
    check("bp_head", out_data, 16'hA001);
    set_sample(0, 16'hA003);
    step();
    check("bp_ack_still_full", in_ack[0], 0);
    check("bp_head_stable", out_data, 16'hA001);
    out_ack = 1'b1;
    step();
    check("bp_ack_after_pop", in_ack[0], 1);
    out_ack = 1'b0;
    step();
    in_req = '0;
    check("bp_third_taken", in_ack[0], 0);

`ifndef STREAM_INTERLEAVER_ZERO_FILL_EN
    // Empty slot stalls until its stream supplies data
    do_reset();
    out_ack = 1'b1;
    set_sample(0, 16'hAAAA);
    set_sample(2, 16'hCCCC);
    in_req = 13'b0_0000_0000_0101;
    step();
    in_req = '0;
    check("stall_s0_req", out_req, 1);
    check("stall_s0_data", out_data, 16'hAAAA);
    check("stall_s0_stream", out_stream, 0);
    step();
    check("stall_s1_req", out_req, 0);
    check("stall_s1_stream", out_stream, 1);
    repeat (3) step();
    check("stall_s1_wait_req", out_req, 0);
    check("stall_s1_wait_stream", out_stream, 1);
    set_sample(1, 16'hBBBB);
    in_req = 13'b0_0000_0000_0010;
    step();
    in_req = '0;
    check("stall_s1_data", out_data, 16'hBBBB);
    check("stall_s1_go_req", out_req, 1);
    step();
    check("stall_s2_data", out_data, 16'hCCCC);
    check("stall_s2_stream", out_stream, 2);
    out_ack = 1'b0;
    set_sample(2, 16'hC2C2);
    in_req = 13'b0_0000_0000_0100;
    step();
    in_req = '0;
    step();
    check("hold_req", out_req, 1);
    check("hold_data", out_data, 16'hCCCC);
    check("hold_stream", out_stream, 2);
    out_ack = 1'b1;
    step();
    check("hold_release_stream", out_stream, 3);
    check("hold_release_req", out_req, 0);
`else
    // Zero fill for empty slots between two stream-0 samples
    do_reset();
    out_ack = 1'b1;
    set_sample(0, 16'h0100);
    in_req = 13'h0001;
    step();
    check("zf_first_req", out_req, 1);
    check("zf_first_data", out_data, 16'h0100);
    check("zf_first_stream", out_stream, 0);
    step();
    in_req = '0;
    for (int k = 1; k < NS; k++) begin
      check("zf_fill_req", out_req, 1);
      check("zf_fill_data", out_data, 0);
      check("zf_fill_stream", out_stream, k);
      step();
    end
    check("zf_second_data", out_data, 16'h0100);
    check("zf_second_stream", out_stream, 0);
    step();
    check("zf_empty_req", out_req, 0);
`endif

    // All streams continuously writing, random consumer stalls
    do_reset();
    for (int i = 0; i < NS; i++) begin
      wr_seq[i] = 0;
      rd_seq[i] = 0;
    end
    exp_slot = 0;
    wraps    = 0;
    n_out    = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NS; i++) begin
        set_sample(i, DW'(((i + 1) << 12) | (wr_seq[i] & 32'hfff)));
      end
      in_req  = '1;
      out_ack = 1'($urandom_range(0, 1));
      #1;
      acc = in_ack & in_req;
      if (out_req && out_ack) begin
        check("rr_stream", out_stream, exp_slot);
        check("rr_data", out_data, DW'(((exp_slot + 1) << 12) | (rd_seq[exp_slot] & 32'hfff)));
        rd_seq[exp_slot]++;
        n_out++;
        if (exp_slot == NS - 1) begin
          exp_slot = 0;
          wraps++;
        end else begin
          exp_slot++;
        end
      end
      step();
      for (int i = 0; i < NS; i++) begin
        if (acc[i]) wr_seq[i]++;
      end
    end
    in_req  = '0;
    out_ack = 1'b0;
    check("rr_wrapped", (wraps > 5) ? 1 : 0, 1);
    check("rr_outputs", (n_out > 100) ? 1 : 0, 1);

    // Async reset with buffered samples discards them
    do_reset();
    out_ack = 1'b0;
    in_req  = 13'h0001;
    set_sample(0, 16'h5555);
    step();
    set_sample(0, 16'h6666);
    step();
    in_req = '0;
    check("arst_pre_req", out_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req_drop", out_req, 0);
    check("arst_data_clr", out_data, 0);
    check("arst_in_ack", in_ack, 0);
    step();
    rst     = 1'b0;
    out_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("arst_no_replay", out_req, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
